// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity helper.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   // Narrower data words are zero-extended by the caller; zeros do not alter XOR.
   function automatic logic parity_calc(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/rx_bit_sync.sv
// Two-flop synchronizer for an idle-high asynchronous input.
module rx_bit_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, optional parity, stop check and a
// one-entry valid/ready holding register with single-cycle error pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 Rx_ready,
   output logic [DATA_BITS-1:0] Rx_data,
   output logic                 Rx_valid,
   output logic                 framing_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic           ODD      = (PARITY_ODD != 0);

   rx_state_t            state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_bad;
   logic                 rx_s;
   logic                 half_end, bit_end, stop_sample, good;

   rx_bit_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      half_end    = (cnt == CNT_HALF);
      bit_end     = (cnt == CNT_FULL);
      stop_sample = 1'b0;
      case (state)
         IDLE:   if (!rx_s) state_nxt = START;
         START:  if (half_end) state_nxt = rx_s ? IDLE : DATA;
         DATA:   if (bit_end && bit_idx == LAST_BIT)
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY: if (bit_end) state_nxt = STOP;
         STOP:   if (bit_end) begin
                    state_nxt   = IDLE;
                    stop_sample = 1'b1;
                 end
         default: state_nxt = IDLE;
      endcase
      good = stop_sample && rx_s && !par_bad;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         par_bad   <= 1'b0;
      end else begin
         case (state)
            IDLE: cnt <= '0;
            START: begin
               cnt     <= half_end ? '0 : cnt + 1'b1;
               bit_idx <= '0;
               par_bad <= 1'b0;
            end
            DATA: begin
               cnt <= bit_end ? '0 : cnt + 1'b1;
               if (bit_end) begin
                  shift_reg[bit_idx] <= rx_s;
                  bit_idx            <= bit_idx + 1'b1;
               end
            end
            PARITY: begin
               cnt <= bit_end ? '0 : cnt + 1'b1;
               if (bit_end) par_bad <= (rx_s != parity_calc(8'(shift_reg), ODD));
            end
            STOP: cnt <= bit_end ? '0 : cnt + 1'b1;
            default: cnt <= '0;
         endcase
      end
   end

   // Frame results register on the stop-sample edge, so they appear one cycle after it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Rx_data     <= '0;
         Rx_valid    <= 1'b0;
         framing_err <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         framing_err <= stop_sample && !rx_s;
         parity_err  <= stop_sample && par_bad;
         overrun_err <= good && Rx_valid && !Rx_ready;
         if (good && (!Rx_valid || Rx_ready)) begin
            Rx_data  <= shift_reg;
            Rx_valid <= 1'b1;
         end else if (Rx_valid && Rx_ready) begin
            Rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an even-parity instance.
module tb_uart_rx;

   logic            clk = 1'b0;
   logic [1:0]      rst_n = 2'b00;
   logic [1:0]      rx = 2'b11;
   logic [1:0]      rdy = 2'b11;
   logic [1:0]      valid, ferr, perr, oerr, busy;
   logic [1:0][7:0] data;

   int checks = 0;
   int failures = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int n_load[2], n_ferr[2], n_perr[2], n_oerr[2], n_vcyc[2];
   logic [1:0]      pv = '0, pr = '0, pb = '0;
   logic [1:0][7:0] pd = '0;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
      .clk(clk), .reset(rst_n[0]), .rx(rx[0]), .Rx_ready(rdy[0]), .Rx_data(data[0]),
      .Rx_valid(valid[0]), .framing_err(ferr[0]), .parity_err(perr[0]),
      .overrun_err(oerr[0]), .busy(busy[0])
   );

   uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .clk(clk), .reset(rst_n[1]), .rx(rx[1]), .Rx_ready(rdy[1]), .Rx_data(data[1]),
      .Rx_valid(valid[1]), .framing_err(ferr[1]), .parity_err(perr[1]),
      .overrun_err(oerr[1]), .busy(busy[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // A new byte is visible when valid is high and the previous cycle left the register free.
   always @(negedge clk) begin : monitor
      logic [7:0] e;
      int sz;
      for (int d = 0; d < 2; d++) begin
         if (ferr[d]) n_ferr[d]++;
         if (perr[d]) n_perr[d]++;
         if (oerr[d]) n_oerr[d]++;
         if (valid[d]) n_vcyc[d]++;
         if (valid[d] && (!pv[d] || pr[d])) begin
            n_load[d]++;
            check("busy_fall_at_load", {30'd0, pb[d], busy[d]}, 32'd2);
            sz = (d == 0) ? q0.size() : q1.size();
            check("byte_expected", (sz != 0), 1);
            if (sz != 0) begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               check("rx_data", data[d], e);
            end
         end
         if (pv[d] && !pr[d] && rst_n[d]) begin
            check("hold_valid", valid[d], 1);
            check("hold_data", data[d], pd[d]);
         end
         pv[d] = valid[d];
         pr[d] = rdy[d];
         pb[d] = busy[d];
         pd[d] = data[d];
      end
   end

   task automatic send_frame(input int d, input logic [7:0] b, input bit par_en,
                             input logic par_bit, input logic stop_bit, input int rst_at);
      logic [10:0] fr;
      int n;
      fr = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[i+1] = b[i];
      n = 9;
      if (par_en) begin
         fr[9] = par_bit;
         n = 10;
      end
      fr[n] = stop_bit;
      n++;
      for (int i = 0; i < n; i++) begin
         rx[d] = fr[i];
         if (i == rst_at) begin
            repeat (8) @(negedge clk);
            check("busy_before_reset", busy[d], 1);
            @(posedge clk);
            #2 rst_n[d] = 1'b0;
            #1 check("outputs_in_reset",
                     {valid[d], ferr[d], perr[d], oerr[d], busy[d], data[d]}, 0);
            @(posedge clk);
            #2 rst_n[d] = 1'b1;
            repeat (7) @(negedge clk);
         end else begin
            repeat (16) @(negedge clk);
         end
      end
      rx[d] = 1'b1;
   endtask

   task automatic check_counts(input int d, input int ld, input int fe, input int pe, input int oe);
      check("load_count", n_load[d], ld);
      check("framing_count", n_ferr[d], fe);
      check("parity_count", n_perr[d], pe);
      check("overrun_count", n_oerr[d], oe);
      check("queue_drained", (d == 0) ? q0.size() : q1.size(), 0);
   endtask

   initial begin
      int vc;
      repeat (3) @(negedge clk);
      check("reset_outputs_a", {valid[0], ferr[0], perr[0], oerr[0], busy[0], data[0]}, 0);
      check("reset_outputs_b", {valid[1], ferr[1], perr[1], oerr[1], busy[1], data[1]}, 0);
      rst_n = 2'b11;
      repeat (4) @(negedge clk);

      // 1: 0xA5 8N1 with ready held high
      vc = n_vcyc[0];
      q0.push_back(8'hA5);
      send_frame(0, 8'hA5, 0, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
      check("valid_pulse_len", n_vcyc[0] - vc, 1);
      check_counts(0, 1, 0, 0, 0);

      // 2: short low glitch, then 0x3C
      rx[0] = 1'b0;
      repeat (4) @(negedge clk);
      rx[0] = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_after_glitch", busy[0], 0);
      check_counts(0, 1, 0, 0, 0);
      q0.push_back(8'h3C);
      send_frame(0, 8'h3C, 0, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
      check_counts(0, 2, 0, 0, 0);

      // 3: 0x5A with stop bit low
      send_frame(0, 8'h5A, 0, 1'b0, 1'b0, -1);
      repeat (24) @(negedge clk);
      check("idle_after_framing", busy[0], 0);
      check("valid_after_framing", valid[0], 0);
      check_counts(0, 2, 1, 0, 0);

      // 4: overrun with ready low
      @(posedge clk);
      #2 rdy[0] = 1'b0;
      @(negedge clk);
      q0.push_back(8'h11);
      send_frame(0, 8'h11, 0, 1'b0, 1'b1, -1);
      send_frame(0, 8'h22, 0, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
      check("overrun_valid", valid[0], 1);
      check("overrun_data", data[0], 8'h11);
      check_counts(0, 3, 1, 0, 1);
      @(posedge clk);
      #2 rdy[0] = 1'b1;
      @(posedge clk);
      #2 rdy[0] = 1'b0;
      @(negedge clk);
      check("valid_after_consume", valid[0], 0);
      @(posedge clk);
      #2 rdy[0] = 1'b1;
      @(negedge clk);

      // 6: reset during data bit 3, then 0xFF
      send_frame(0, 8'hF8, 0, 1'b0, 1'b1, 4);
      repeat (20) @(negedge clk);
      check_counts(0, 3, 1, 0, 1);
      q0.push_back(8'hFF);
      send_frame(0, 8'hFF, 0, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
      check_counts(0, 4, 1, 0, 1);

      // 5: even parity, 0x07 needs parity bit 1
      send_frame(1, 8'h07, 1, 1'b0, 1'b1, -1);
      repeat (4) @(negedge clk);
      check("valid_after_parity_err", valid[1], 0);
      check_counts(1, 0, 0, 1, 0);
      q1.push_back(8'h07);
      send_frame(1, 8'h07, 1, 1'b1, 1'b1, -1);
      repeat (4) @(negedge clk);
      check_counts(1, 1, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; the receive-side counterpart of the transmit path and its ready handshake.
- Function: synchronizes the asynchronous `rx` line, detects the start bit, samples each bit at mid-bit, checks optional parity and the stop bit.
- Output: the received byte is presented on a one-entry valid/ready holding register, with single-cycle error pulses.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be ≥4 and even.
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- Rx_ready  input  1  consumer accepts Rx_data when high with Rx_valid
- Rx_data  output  DATA_BITS  received byte, stable while Rx_valid=1
- Rx_valid  output  1  Rx_data holds an unconsumed byte
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch
- overrun_err  output  1  one-cycle pulse: good byte dropped because the holding register was full
- busy  output  1  high while the FSM is not IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, port reset.
- Reset values: all outputs 0. Synchronizer flops = 1. FSM = IDLE. Counters = 0.
- Reset mid-frame aborts the frame silently; no error pulse.
- Synchronizer: 2 flops; rx_s is the second-flop output. All decisions use rx_s.
- Counter: cnt counts clk cycles within a bit. bit_idx counts data bits.
- IDLE:
  - rx_s=0 → START, cnt=0.
- START:
  - At cnt=CLKS_PER_BIT/2-1, sample rx_s.
  - 0 → DATA, cnt=0, bit_idx=0.
  - 1 → IDLE. This is a glitch; no error is raised.
- DATA:
  - At cnt=CLKS_PER_BIT-1, shift rx_s into shift[bit_idx] and reset cnt.
  - After bit DATA_BITS-1 → PARITY if PARITY_EN, else STOP.
- PARITY:
  - At cnt=CLKS_PER_BIT-1, compare rx_s with the expected value.
  - Expected value = XOR(data) ^ PARITY_ODD.
  - Latch the mismatch flag; → STOP.
- STOP:
  - At cnt=CLKS_PER_BIT-1 (mid stop bit), sample rx_s; → IDLE on the same edge.
  - The IDLE state is therefore ready for the next start edge half a bit early.
- End of frame, in the cycle after the stop sample:
  - rx_s=0 at the stop sample: framing_err pulses 1 cycle; the byte is discarded.
  - Parity mismatch: parity_err pulses 1 cycle; the byte is discarded.
  - Both conditions: both error signals pulse.
  - Good frame with the holding register empty, or being emptied this cycle (Rx_valid&&Rx_ready): Rx_data is loaded and Rx_valid=1.
  - Good frame with Rx_valid=1 and Rx_ready=0: overrun_err pulses; Rx_data and Rx_valid are unchanged.
- Handshake:
  - Rx_valid&&Rx_ready at a rising edge consumes the byte; Rx_valid falls next cycle unless a new byte loads in the same cycle.
  - Rx_data never changes while Rx_valid=1 and Rx_ready=0.
  - Rx_ready with Rx_valid=0 has no effect.
- Latency:
  - rx falling edge → START entered 2 cycles later (synchronizer) + 1 cycle.
  - Rx_valid rises 1 cycle after the stop sample.
- busy=1 in START, DATA, PARITY and STOP.
- The rx line is ignored during STOP after the sample. A low rx during DATA/STOP is simply data; no resynchronization occurs mid-frame.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Function parity_calc(data, odd), shared with the transmitter.
- Sub-module rx_bit_sync: 2-flop synchronizer with reset value 1, instantiated once for rx.
- FSM, counters and holding register stay in uart_rx.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
1. Send 0xA5, 8N1, with Rx_ready=1 → Rx_valid pulses 1 cycle with Rx_data=0xA5; no error pulses; busy falls at the stop sample.
2. Pulse rx low for 4 cycles, then high → no Rx_valid, no errors, FSM returns to IDLE; a following 0x3C is then received correctly.
3. Send 0x5A with the stop bit driven 0 → framing_err pulses once; Rx_valid stays 0.
4. Hold Rx_ready=0 and send 0x11 then 0x22 back-to-back → Rx_data=0x11, Rx_valid=1, overrun_err pulses once at the end of frame 2. After Rx_ready=1 for one cycle, Rx_valid=0.
5. PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 (correct value 1) → parity_err pulses; no Rx_valid. Resend with parity 1 → Rx_data=0x07.
6. Assert reset for 1 cycle during data bit 3 → all outputs 0 and no error pulse; the next frame 0xFF is received as 0xFF.
